// File: rtl/id_ex_pipe_regs.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_regs
//
// Pipeline registers on the consuming end of the hazard unit's control
// interface. This block owns three register stages:
//   - the PC register (Fetch),
//   - the IF/ID register (Decode),
//   - the ID/EX register (Execute).
// It also keeps two saturating statistics counters.
//
// The register specifiers and the load indicator that the hazard unit needs
// are exported: rs1_d/rs2_d, and rs1_e/rs2_e/rd_e/result_src_e.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   pc_next_f                next PC (PC+4 or redirect target)
//   instr_f, pc_plus4_f      fetched instruction and its PC+4
//   stall_f                  hold the PC register
//   stall_d                  hold IF/ID and push a bubble into ID/EX
//   flush_d, flush_e         clear IF/ID, clear ID/EX
//   *_d decode controls/data captured into ID/EX
//   pc_f                     current PC
//   instr_d, pc_d,
//   pc_plus4_d, valid_d      IF/ID contents
//   rs1_d, rs2_d, rd_d       register fields of instr_d (combinational)
//   *_e                      ID/EX contents
//   stall_cnt, flush_cnt     saturating statistics counters
// -----------------------------------------------------------------------------
module id_ex_pipe_regs #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_next_f,
  input  logic [31:0]     instr_f,
  input  logic [XLEN-1:0] pc_plus4_f,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            flush_e,
  input  logic            reg_write_d,
  input  logic            mem_write_d,
  input  logic            jump_d,
  input  logic            branch_d,
  input  logic            alu_src_d,
  input  logic [1:0]      result_src_d,
  input  logic [2:0]      alu_ctrl_d,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [XLEN-1:0] imm_ext_d,
  output logic [XLEN-1:0] pc_f,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d,
  output logic [4:0]      rs1_d,
  output logic [4:0]      rs2_d,
  output logic [4:0]      rd_d,
  output logic            reg_write_e,
  output logic            mem_write_e,
  output logic            jump_e,
  output logic            branch_e,
  output logic            alu_src_e,
  output logic            valid_e,
  output logic [1:0]      result_src_e,
  output logic [2:0]      alu_ctrl_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] imm_ext_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pc_plus4_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // addi x0, x0, 0 -- what an empty Decode slot holds
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // ---------------------------------------------------------------------------
  // PC register
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] pc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else if (!stall_f) begin
      pc_reg <= pc_next_f;
    end
  end

  assign pc_f = pc_reg;

  // ---------------------------------------------------------------------------
  // IF/ID register. A flush beats a stall, so a squashed slot cannot be
  // held with stale contents.
  // ---------------------------------------------------------------------------
  logic [31:0]     instr_d_reg;
  logic [XLEN-1:0] pc_d_reg;
  logic [XLEN-1:0] pc_plus4_d_reg;
  logic            valid_d_reg;

  always_ff @(posedge clk) begin
    if (rst || flush_d) begin
      instr_d_reg    <= NOP_INSTR;
      pc_d_reg       <= '0;
      pc_plus4_d_reg <= '0;
      valid_d_reg    <= 1'b0;
    end else if (!stall_d) begin
      instr_d_reg    <= instr_f;
      pc_d_reg       <= pc_reg;
      pc_plus4_d_reg <= pc_plus4_f;
      valid_d_reg    <= 1'b1;
    end
  end

  assign instr_d    = instr_d_reg;
  assign pc_d       = pc_d_reg;
  assign pc_plus4_d = pc_plus4_d_reg;
  assign valid_d    = valid_d_reg;

  // Register fields feed the hazard unit straight from the IF/ID register.
  assign rs1_d = instr_d_reg[19:15];
  assign rs2_d = instr_d_reg[24:20];
  assign rd_d  = instr_d_reg[11:7];

  // ---------------------------------------------------------------------------
  // ID/EX register. Never held: while Decode is stalled the instruction stays
  // in IF/ID and Execute receives a bubble instead, so the stalled
  // instruction is not issued twice. A bubble zeroes everything, which keeps
  // reg_write/mem_write/jump/branch low for the empty slot.
  // ---------------------------------------------------------------------------
  logic bubble_e;
  assign bubble_e = flush_e | stall_d;

  logic            reg_write_e_reg;
  logic            mem_write_e_reg;
  logic            jump_e_reg;
  logic            branch_e_reg;
  logic            alu_src_e_reg;
  logic            valid_e_reg;
  logic [1:0]      result_src_e_reg;
  logic [2:0]      alu_ctrl_e_reg;
  logic [XLEN-1:0] rd1_e_reg;
  logic [XLEN-1:0] rd2_e_reg;
  logic [XLEN-1:0] imm_ext_e_reg;
  logic [XLEN-1:0] pc_e_reg;
  logic [XLEN-1:0] pc_plus4_e_reg;
  logic [4:0]      rs1_e_reg;
  logic [4:0]      rs2_e_reg;
  logic [4:0]      rd_e_reg;

  always_ff @(posedge clk) begin
    if (rst || bubble_e) begin
      reg_write_e_reg  <= 1'b0;
      mem_write_e_reg  <= 1'b0;
      jump_e_reg       <= 1'b0;
      branch_e_reg     <= 1'b0;
      alu_src_e_reg    <= 1'b0;
      valid_e_reg      <= 1'b0;
      result_src_e_reg <= '0;
      alu_ctrl_e_reg   <= '0;
      rd1_e_reg        <= '0;
      rd2_e_reg        <= '0;
      imm_ext_e_reg    <= '0;
      pc_e_reg         <= '0;
      pc_plus4_e_reg   <= '0;
      rs1_e_reg        <= '0;
      rs2_e_reg        <= '0;
      rd_e_reg         <= '0;
    end else begin
      reg_write_e_reg  <= reg_write_d;
      mem_write_e_reg  <= mem_write_d;
      jump_e_reg       <= jump_d;
      branch_e_reg     <= branch_d;
      alu_src_e_reg    <= alu_src_d;
      valid_e_reg      <= valid_d_reg;
      result_src_e_reg <= result_src_d;
      alu_ctrl_e_reg   <= alu_ctrl_d;
      rd1_e_reg        <= rd1_d;
      rd2_e_reg        <= rd2_d;
      imm_ext_e_reg    <= imm_ext_d;
      pc_e_reg         <= pc_d_reg;
      pc_plus4_e_reg   <= pc_plus4_d_reg;
      rs1_e_reg        <= instr_d_reg[19:15];
      rs2_e_reg        <= instr_d_reg[24:20];
      rd_e_reg         <= instr_d_reg[11:7];
    end
  end

  assign reg_write_e  = reg_write_e_reg;
  assign mem_write_e  = mem_write_e_reg;
  assign jump_e       = jump_e_reg;
  assign branch_e     = branch_e_reg;
  assign alu_src_e    = alu_src_e_reg;
  assign valid_e      = valid_e_reg;
  assign result_src_e = result_src_e_reg;
  assign alu_ctrl_e   = alu_ctrl_e_reg;
  assign rd1_e        = rd1_e_reg;
  assign rd2_e        = rd2_e_reg;
  assign imm_ext_e    = imm_ext_e_reg;
  assign pc_e         = pc_e_reg;
  assign pc_plus4_e   = pc_plus4_e_reg;
  assign rs1_e        = rs1_e_reg;
  assign rs2_e        = rs2_e_reg;
  assign rd_e         = rd_e_reg;

  // ---------------------------------------------------------------------------
  // Statistics counters: index 0 counts stall cycles, index 1 flush cycles.
  // They stick at all-ones instead of wrapping so a long run never reports a
  // misleadingly small number.
  // ---------------------------------------------------------------------------
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_reg [2];

  assign cnt_inc[0] = stall_d;
  assign cnt_inc[1] = flush_d | flush_e;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign stall_cnt = cnt_reg[0];
  assign flush_cnt = cnt_reg[1];

endmodule

// File: tb/tb_id_ex_pipe_regs.sv
// -----------------------------------------------------------------------------
// tb_id_ex_pipe_regs
//
// Drives id_ex_pipe_regs (CNT_W = 4 so saturation is reachable quickly)
// through:
//   - a table of directed vectors: reset, free run, load-use stall,
//     branch flush, stall+flush, and reset during a stall;
//   - a counter saturation sequence;
//   - randomized cycles checked against a behavioural stage model.
// -----------------------------------------------------------------------------
module tb_id_ex_pipe_regs;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] pc_next_f;
  logic [31:0]     instr_f;
  logic [XLEN-1:0] pc_plus4_f;
  logic            stall_f, stall_d, flush_d, flush_e;
  logic            reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
  logic [1:0]      result_src_d;
  logic [2:0]      alu_ctrl_d;
  logic [XLEN-1:0] rd1_d, rd2_d, imm_ext_d;

  logic [XLEN-1:0] pc_f;
  logic [31:0]     instr_d;
  logic [XLEN-1:0] pc_d, pc_plus4_d;
  logic            valid_d;
  logic [4:0]      rs1_d, rs2_d, rd_d;
  logic            reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, valid_e;
  logic [1:0]      result_src_e;
  logic [2:0]      alu_ctrl_e;
  logic [XLEN-1:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
  logic [4:0]      rs1_e, rs2_e, rd_e;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  id_ex_pipe_regs #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .pc_next_f(pc_next_f), .instr_f(instr_f), .pc_plus4_f(pc_plus4_f),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .reg_write_d(reg_write_d), .mem_write_d(mem_write_d), .jump_d(jump_d),
    .branch_d(branch_d), .alu_src_d(alu_src_d), .result_src_d(result_src_d),
    .alu_ctrl_d(alu_ctrl_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_ext_d(imm_ext_d),
    .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .jump_e(jump_e),
    .branch_e(branch_e), .alu_src_e(alu_src_e), .valid_e(valid_e),
    .result_src_e(result_src_e), .alu_ctrl_e(alu_ctrl_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e), .pc_e(pc_e),
    .pc_plus4_e(pc_plus4_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: each stage is a record; a clock edge moves records
  // forward according to the hold/flush/bubble rules.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        reg_write, mem_write, jump, branch, alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_ctrl;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic        valid;
  } e_rec_t;

  typedef struct packed {
    logic [31:0] instr, pc, pc4;
    logic        valid;
  } d_rec_t;

  localparam d_rec_t D_EMPTY = '{instr: 32'h0000_0013, pc: 32'h0, pc4: 32'h0, valid: 1'b0};

  logic [31:0] m_pc;
  d_rec_t      m_d;
  e_rec_t      m_e;
  int          m_scnt, m_fcnt;

  task automatic model_edge();
    e_rec_t nxt_e;
    if (rst) begin
      m_pc = 32'h0; m_d = D_EMPTY; m_e = '0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (flush_e || stall_d) nxt_e = '0;
      else nxt_e = '{reg_write: reg_write_d, mem_write: mem_write_d, jump: jump_d,
                     branch: branch_d, alu_src: alu_src_d, result_src: result_src_d,
                     alu_ctrl: alu_ctrl_d, rd1: rd1_d, rd2: rd2_d, imm: imm_ext_d,
                     pc: m_d.pc, pc4: m_d.pc4, rs1: m_d.instr[19:15],
                     rs2: m_d.instr[24:20], rd: m_d.instr[11:7], valid: m_d.valid};
      m_e = nxt_e;
      if (flush_d) m_d = D_EMPTY;
      else if (!stall_d) m_d = '{instr: instr_f, pc: m_pc, pc4: pc_plus4_f, valid: 1'b1};
      if (!stall_f) m_pc = pc_next_f;
      if (stall_d && m_scnt < CNT_MAX) m_scnt++;
      if ((flush_d || flush_e) && m_fcnt < CNT_MAX) m_fcnt++;
    end
  endtask

  task automatic cmp_all(input string tag);
    e_rec_t dut_e;
    dut_e = '{reg_write: reg_write_e, mem_write: mem_write_e, jump: jump_e,
              branch: branch_e, alu_src: alu_src_e, result_src: result_src_e,
              alu_ctrl: alu_ctrl_e, rd1: rd1_e, rd2: rd2_e, imm: imm_ext_e,
              pc: pc_e, pc4: pc_plus4_e, rs1: rs1_e, rs2: rs2_e, rd: rd_e,
              valid: valid_e};
    chk({tag, ".pc_f"}, pc_f, m_pc);
    chk({tag, ".ifid"}, {instr_d, pc_d, pc_plus4_d, valid_d}, m_d);
    chk({tag, ".dec"}, {rs1_d, rs2_d, rd_d}, {m_d.instr[19:15], m_d.instr[24:20], m_d.instr[11:7]});
    chk({tag, ".idex"}, dut_e, m_e);
    chk({tag, ".stall_cnt"}, stall_cnt, m_scnt);
    chk({tag, ".flush_cnt"}, flush_cnt, m_fcnt);
  endtask

  // One clock: inputs already applied; model follows the edge, outputs are
  // sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        rst, sf, sd, fd, fe;
    logic [31:0] pc_next, instr;
    logic [31:0] e_pc, e_instr_d;
    logic        e_valid_d;
    logic [4:0]  e_rd_d;
    logic        e_valid_e;
    logic [4:0]  e_rd_e;
    logic        e_regw_e;
    logic [3:0]  e_scnt, e_fcnt;
  } vec_t;

  function automatic vec_t mk(
      input logic r, sf, sd, fd, fe, input logic [31:0] pn, ins,
      input logic [31:0] epc, eins, input logic evd, input logic [4:0] erdd,
      input logic eve, input logic [4:0] erde, input logic erw,
      input logic [3:0] esc, efc);
    vec_t v;
    v.rst = r; v.sf = sf; v.sd = sd; v.fd = fd; v.fe = fe;
    v.pc_next = pn; v.instr = ins;
    v.e_pc = epc; v.e_instr_d = eins; v.e_valid_d = evd; v.e_rd_d = erdd;
    v.e_valid_e = eve; v.e_rd_e = erde; v.e_regw_e = erw;
    v.e_scnt = esc; v.e_fcnt = efc;
    return v;
  endfunction

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0050_0093;  // rd=1
  localparam logic [31:0] LW   = 32'h0020_A183;  // rd=3

  vec_t tbl[12];

  initial begin
    // rst sf sd fd fe  pc_next  instr_f  | pc_f     instr_d vd rd_d ve rd_e rw sc fc
    tbl[0]  = mk(1, 0, 0, 0, 0, 32'h00, ADDI,  32'h00, NOP,  0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 32'h04, ADDI,  32'h04, ADDI, 1, 1, 0, 0, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 32'h08, ADDI,  32'h08, ADDI, 1, 1, 1, 1, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 32'h0C, LW,    32'h0C, LW,   1, 3, 1, 1, 1, 0, 0);
    tbl[4]  = mk(0, 1, 1, 0, 0, 32'h10, ADDI,  32'h0C, LW,   1, 3, 0, 0, 0, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 32'h10, ADDI,  32'h10, ADDI, 1, 1, 1, 3, 1, 1, 0);
    tbl[6]  = mk(0, 0, 0, 1, 1, 32'h64, ADDI,  32'h64, NOP,  0, 0, 0, 0, 0, 1, 1);
    tbl[7]  = mk(0, 0, 1, 1, 0, 32'h68, ADDI,  32'h68, NOP,  0, 0, 0, 0, 0, 2, 2);
    tbl[8]  = mk(0, 0, 0, 0, 0, 32'h6C, ADDI,  32'h6C, ADDI, 1, 1, 0, 0, 1, 2, 2);
    tbl[9]  = mk(0, 1, 1, 0, 0, 32'h70, ADDI,  32'h6C, ADDI, 1, 1, 0, 0, 0, 3, 2);
    tbl[10] = mk(1, 1, 1, 0, 1, 32'h74, ADDI,  32'h00, NOP,  0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 32'h04, ADDI,  32'h04, ADDI, 1, 1, 0, 0, 1, 0, 0);

    // Decode controls held constant for the directed part; reg_write_d = 1
    // shows whether ID/EX captured or bubbled.
    reg_write_d = 1'b1; mem_write_d = 1'b1; jump_d = 1'b0; branch_d = 1'b0;
    alu_src_d = 1'b1; result_src_d = 2'b01; alu_ctrl_d = 3'b010;
    rd1_d = 32'h1111_1111; rd2_d = 32'h2222_2222; imm_ext_d = 32'h0000_0005;

    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; stall_f = tbl[i].sf; stall_d = tbl[i].sd;
      flush_d = tbl[i].fd; flush_e = tbl[i].fe;
      pc_next_f = tbl[i].pc_next; instr_f = tbl[i].instr;
      pc_plus4_f = tbl[i].pc_next;
      step();
      $display("vec %0d: pc_f=%h instr_d=%h valid_d=%b valid_e=%b rd_e=%0d stall_cnt=%0d flush_cnt=%0d",
               i, pc_f, instr_d, valid_d, valid_e, rd_e, stall_cnt, flush_cnt);
      chk($sformatf("vec%0d.pc_f", i), pc_f, tbl[i].e_pc);
      chk($sformatf("vec%0d.instr_d", i), instr_d, tbl[i].e_instr_d);
      chk($sformatf("vec%0d.valid_d", i), valid_d, tbl[i].e_valid_d);
      chk($sformatf("vec%0d.rd_d", i), rd_d, tbl[i].e_rd_d);
      chk($sformatf("vec%0d.valid_e", i), valid_e, tbl[i].e_valid_e);
      chk($sformatf("vec%0d.rd_e", i), rd_e, tbl[i].e_rd_e);
      chk($sformatf("vec%0d.reg_write_e", i), reg_write_e, tbl[i].e_regw_e);
      chk($sformatf("vec%0d.stall_cnt", i), stall_cnt, tbl[i].e_scnt);
      chk($sformatf("vec%0d.flush_cnt", i), flush_cnt, tbl[i].e_fcnt);
      // A bubble slot must look empty on every side-effecting control.
      if (tbl[i].sd || tbl[i].fe || tbl[i].rst)
        chk($sformatf("vec%0d.bubble_ctrl", i),
            {reg_write_e, mem_write_e, jump_e, branch_e, result_src_e}, 6'b0);
    end

    // -------------------------------------------------------------------------
    // Counter saturation: stall_d held for 20 cycles with CNT_W = 4.
    // -------------------------------------------------------------------------
    rst = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; flush_e = 1'b0;
    step();
    rst = 1'b0; stall_d = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      $display("sat %0d: stall_cnt=%0d", i, stall_cnt);
      chk($sformatf("sat%0d.stall_cnt", i), stall_cnt, (i + 1 > CNT_MAX) ? CNT_MAX : i + 1);
    end
    chk("sat.idex_bubble", {valid_e, reg_write_e, mem_write_e}, 3'b000);
    chk("sat.flush_cnt", flush_cnt, 0);

    // -------------------------------------------------------------------------
    // Randomized cycles against the behavioural model.
    // -------------------------------------------------------------------------
    rst = 1'b1; stall_d = 1'b0;
    step();
    cmp_all("rnd_rst");
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 39) == 0);
      stall_f      = ($urandom_range(0, 3) == 0);
      stall_d      = ($urandom_range(0, 3) == 0);
      flush_d      = ($urandom_range(0, 6) == 0);
      flush_e      = ($urandom_range(0, 6) == 0);
      pc_next_f    = $urandom;
      instr_f      = $urandom;
      pc_plus4_f   = $urandom;
      reg_write_d  = 1'($urandom);
      mem_write_d  = 1'($urandom);
      jump_d       = 1'($urandom);
      branch_d     = 1'($urandom);
      alu_src_d    = 1'($urandom);
      result_src_d = 2'($urandom);
      alu_ctrl_d   = 3'($urandom);
      rd1_d        = $urandom;
      rd2_d        = $urandom;
      imm_ext_d    = $urandom;
      step();
      $display("rnd %0d: rst=%b sf=%b sd=%b fd=%b fe=%b pc_f=%h instr_d=%h valid_e=%b",
               i, rst, stall_f, stall_d, flush_d, flush_e, pc_f, instr_d, valid_e);
      cmp_all($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
